// File: rtl/mipse_ctrl.sv
// mipse_ctrl -- boot/run sequencer for the mipse single-cycle core.
//
// Takes a program from the host as a byte stream, writes it into instruction
// memory, and keeps the core in reset until the whole image is in place. It
// then releases the core and counts cycles until the core raises finish.
//
// Stream format: 16-bit big-endian word count N, then N words of 4 bytes
// each, also big-endian. N = 0 or N > 2^IMEM_AW is rejected with load_err.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, clear          one-cycle pulses: begin a load / return to IDLE
//   in_valid, in_data     host byte stream; in_ready is the accept side
//   imem_we/addr/wdata    instruction-memory write port (one-cycle pulses)
//   core_rst_n            core reset, active-low
//   core_finish           core finish flag
//   busy, done            status: loading or running / session finished
//   timeout, load_err     watchdog expired / bad header
//   cycles                core cycles executed (saturating)
//
// Build option: define MIPSE_CTRL_WDOG_EN to compile in a watchdog that ends
// RUN after MAX_CYCLES core cycles without finish. Without it, timeout is
// constant 0 and MAX_CYCLES has no effect.
module mipse_ctrl #(
  parameter int IMEM_AW    = 8,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               core_rst_n,
  input  logic               core_finish,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               load_err,
  output logic [CNT_W-1:0]   cycles
);

`ifdef MIPSE_CTRL_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, LOAD, RUN, DONE} state_t;

  localparam int unsigned      DEPTH    = 32'd1 << IMEM_AW;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // Compared against the pre-increment count, so the watchdog edge is the
  // one that brings cycles up to MAX_CYCLES.
  localparam logic [CNT_W-1:0] WDOG_LIM = CNT_W'(MAX_CYCLES - 1);

  state_t               state_q, state_d;
  logic [7:0]           hdr_hi_q, hdr_hi_d;
  logic [IMEM_AW-1:0]   nlast_q, nlast_d;   // index of the final word (N-1)
  logic [IMEM_AW-1:0]   idx_q, idx_d;
  logic [1:0]           bcnt_q, bcnt_d;     // byte position within the word
  logic [23:0]          sh_q, sh_d;         // first three bytes of the word

  logic                 imem_we_d;
  logic [IMEM_AW-1:0]   imem_addr_d;
  logic [31:0]          imem_wdata_d;
  logic                 core_rst_n_d, timeout_d, load_err_d;
  logic [CNT_W-1:0]     cycles_d;
  logic                 in_ready_d, busy_d, done_d;

  logic                 acc;
  logic [15:0]          n_word;
  logic                 hdr_bad;

  always_comb begin
    state_d      = state_q;
    hdr_hi_d     = hdr_hi_q;
    nlast_d      = nlast_q;
    idx_d        = idx_q;
    bcnt_d       = bcnt_q;
    sh_d         = sh_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    core_rst_n_d = core_rst_n;
    timeout_d    = timeout;
    load_err_d   = load_err;
    cycles_d     = cycles;
    acc          = in_valid & in_ready;
    n_word       = {hdr_hi_q, in_data};
    hdr_bad      = (n_word == 16'd0) || ({16'd0, n_word} > DEPTH);

    case (state_q)
      IDLE: begin
        core_rst_n_d = 1'b0;
        if (start) begin
          state_d    = HDR0;
          cycles_d   = '0;
          timeout_d  = 1'b0;
          load_err_d = 1'b0;
        end
      end
      HDR0: if (acc) begin
        hdr_hi_d = in_data;
        state_d  = HDR1;
      end
      HDR1: if (acc) begin
        if (hdr_bad) begin
          load_err_d = 1'b1;
          state_d    = DONE;
        end else begin
          nlast_d = IMEM_AW'(n_word - 16'd1);
          idx_d   = '0;
          bcnt_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: if (acc) begin
        bcnt_d = bcnt_q + 2'd1;
        sh_d   = {sh_q[15:0], in_data};
        if (bcnt_q == 2'd3) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = idx_q;
          imem_wdata_d = {sh_q, in_data};
          idx_d        = idx_q + 1'b1;
          // The last write lands in the first RUN cycle; the core is
          // released one edge later, so its first fetch sees every word.
          if (idx_q == nlast_q) state_d = RUN;
        end
      end
      RUN: begin
        core_rst_n_d = 1'b1;
        // finish only means something once the core is out of reset
        if (core_rst_n) begin
          if (core_finish) begin
            state_d = DONE;
          end else begin
            if (cycles != CNT_MAX) cycles_d = cycles + 1'b1;
            if (WDOG_EN && cycles == WDOG_LIM) begin
              state_d      = DONE;
              timeout_d    = 1'b1;
              core_rst_n_d = 1'b0;
            end
          end
        end
      end
      DONE: begin
        // core_rst_n holds so a finished core keeps its PC
      end
      default: state_d = IDLE;
    endcase

    if (clear && state_q != IDLE) begin
      state_d      = IDLE;
      imem_we_d    = 1'b0;
      core_rst_n_d = 1'b0;
    end

    in_ready_d = (state_d == HDR0) || (state_d == HDR1) || (state_d == LOAD);
    busy_d     = in_ready_d || (state_d == RUN);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hdr_hi_q   <= '0;
      nlast_q    <= '0;
      idx_q      <= '0;
      bcnt_q     <= '0;
      sh_q       <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      load_err   <= 1'b0;
      cycles     <= '0;
    end else begin
      state_q    <= state_d;
      hdr_hi_q   <= hdr_hi_d;
      nlast_q    <= nlast_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      sh_q       <= sh_d;
      in_ready   <= in_ready_d;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      core_rst_n <= core_rst_n_d;
      busy       <= busy_d;
      done       <= done_d;
      timeout    <= timeout_d;
      load_err   <= load_err_d;
      cycles     <= cycles_d;
    end
  end

endmodule

// File: tb/tb_mipse_ctrl.sv
// Self-checking bench for mipse_ctrl (IMEM_AW = 8, MAX_CYCLES = 10).
// The reference is the expected program image (a queue of words written to
// consecutive addresses), the header rule N in 1..256, and a core model that
// raises finish a fixed number of released cycles after reset is lifted.
module tb_mipse_ctrl;
  localparam int AW = 8;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n, start, clear, in_valid, core_finish;
  logic [7:0]    in_data;
  logic          in_ready, imem_we, core_rst_n, busy, done, timeout, load_err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [CW-1:0] cycles;

  mipse_ctrl #(.IMEM_AW(AW), .CNT_W(CW), .MAX_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .core_finish(core_finish),
    .busy(busy), .done(done), .timeout(timeout), .load_err(load_err),
    .cycles(cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // core model: finish rises fin_n released cycles after core_rst_n goes high
  int fin_n = 0;
  bit fin_en = 1'b0;
  int k = 0;
  always @(posedge clk) k <= core_rst_n ? k + 1 : 0;
  assign core_finish = fin_en && core_rst_n && (k >= fin_n);

  // monitors sample pre-edge values; inputs only change on negedge
  int cyc = 0;
  int last_hs = -1, last_we = -1, rise_cyc = -1;
  logic rst_prev = 1'b0;
  logic [AW-1:0] wlog_a[$];
  logic [31:0]   wlog_d[$];
  always @(posedge clk) begin
    if (in_valid && in_ready) last_hs = cyc;
    if (imem_we) begin
      wlog_a.push_back(imem_addr);
      wlog_d.push_back(imem_wdata);
      last_we = cyc;
    end
    if (core_rst_n && !rst_prev) rise_cyc = cyc;
    rst_prev = core_rst_n;
    cyc <= cyc + 1;
  end

  logic [31:0] wq[$];  // expected program image

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g = (maxgap > 0) ? int'($urandom_range(maxgap, 1)) : 0;
    int t = 0;
    repeat (g) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    chk("in_ready_wait", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    chk("clr_busy", busy, 1'b0);
    chk("clr_done", done, 1'b0);
    chk("clr_core_rst_n", core_rst_n, 1'b0);
    chk("clr_in_ready", in_ready, 1'b0);
  endtask

  // start a session and stream the header plus (for a good header) wq
  task automatic load(input logic [15:0] n, input bit err, input int maxgap);
    wlog_a.delete(); wlog_d.delete();
    rise_cyc = -1;
    pulse_start();
    chk("start_busy", busy, 1'b1);
    send_byte(n[15:8], maxgap);
    send_byte(n[7:0], maxgap);
    if (!err)
      foreach (wq[i]) for (int j = 3; j >= 0; j--) send_byte(wq[i][8*j +: 8], maxgap);
  endtask

  task automatic check_writes(input int n);
    chk("wr_count", wlog_a.size(), n);
    for (int i = 0; i < n && i < wlog_a.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), wlog_a[i], i[AW-1:0]);
      chk($sformatf("wr_data[%0d]", i), wlog_d[i], wq[i]);
    end
  endtask

  task automatic finish_check(input int n, input bit err, input int fin);
    int t = 0;
    while (!done && t < 60 + fin) begin @(negedge clk); t++; end
    chk("done", done, 1'b1);
    chk("load_err", load_err, err);
    chk("timeout", timeout, 1'b0);
    chk("busy_done", busy, 1'b0);
    if (err) begin
      chk("err_core_rst_n", core_rst_n, 1'b0);
      chk("err_cycles", cycles, 0);
      chk("err_no_we", wlog_a.size(), 0);
    end else begin
      check_writes(n);
      chk("release_latency", rise_cyc - last_hs, 2);
      chk("last_we_latency", last_we - last_hs, 1);
      chk("cycles", cycles, fin);
      chk("done_core_rst_n", core_rst_n, 1'b1);
      repeat (3) @(negedge clk);
      chk("cycles_frozen", cycles, fin);
      chk("core_rst_n_held", core_rst_n, 1'b1);
    end
  endtask

  typedef struct {
    logic [15:0] n;
    int          gap;
    int          fin;
    bit          plan;
    bit          err;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h0002, 0, 5,  1'b1, 1'b0};
    vecs[1] = '{16'h0000, 0, 0,  1'b0, 1'b1};
    vecs[2] = '{16'h0101, 0, 0,  1'b0, 1'b1};
    vecs[3] = '{16'h0100, 0, 3,  1'b0, 1'b0};
    vecs[4] = '{16'h0002, 3, 5,  1'b1, 1'b0};
    vecs[5] = '{16'h0001, 2, 1,  1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 1, 0,  1'b0, 1'b1};
    vecs[7] = '{16'h0007, 3, 17, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_imem_we", imem_we, 1'b0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_core_rst_n", core_rst_n, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_load_err", load_err, 1'b0);
    chk("rst_cycles", cycles, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // bytes offered in IDLE are ignored
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;

    foreach (vecs[v]) begin
      wq.delete();
      if (vecs[v].plan) begin
        wq.push_back(32'h3C081234);
        wq.push_back(32'h1000FFFF);
      end else if (!vecs[v].err) begin
        for (int i = 0; i < int'(vecs[v].n); i++) wq.push_back($urandom);
      end
      fin_n = vecs[v].fin; fin_en = 1'b1;
      load(vecs[v].n, vecs[v].err, vecs[v].gap);
      finish_check(wq.size(), vecs[v].err, vecs[v].fin);
      do_clear();
    end

    // abort after 6 data bytes of a 2-word load; a stray start is ignored
    wq.delete();
    wq.push_back(32'h3C081234);
    wq.push_back(32'h1000FFFF);
    wlog_a.delete(); wlog_d.delete();
    fin_n = 4; fin_en = 1'b1;
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h3C, 0); send_byte(8'h08, 0); send_byte(8'h12, 0);
    pulse_start();
    send_byte(8'h34, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    do_clear();
    repeat (3) @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    check_writes(1);
    load(16'h0002, 1'b0, 0);
    finish_check(2, 1'b0, 4);
    do_clear();

    // core never finishes
    wq.delete();
    wq.push_back($urandom);
    fin_en = 1'b0;
    load(16'h0001, 1'b0, 1);
    begin
      int t = 0;
      while (rise_cyc < 0 && t < 20) begin @(negedge clk); t++; end
      chk("run_released", core_rst_n, 1'b1);
    end
`ifdef MIPSE_CTRL_WDOG_EN
    begin
      int t = 0;
      while (!done && t < 40) begin @(negedge clk); t++; end
    end
    chk("wdog_done", done, 1'b1);
    chk("wdog_timeout", timeout, 1'b1);
    chk("wdog_cycles", cycles, 10);
    chk("wdog_core_rst_n", core_rst_n, 1'b0);
`else
    // bytes offered in RUN are ignored; counting runs past 10
    in_valid = 1'b1;
    repeat (25) begin in_data = $urandom; @(negedge clk); end
    in_valid = 1'b0;
    chk("run_cycles", cycles, cyc - rise_cyc);
    chk("run_timeout", timeout, 1'b0);
    chk("run_busy", busy, 1'b1);
    chk("run_done", done, 1'b0);
    check_writes(1);
`endif
    do_clear();

    // async reset in the middle of a load
    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back($urandom);
    wlog_a.delete(); wlog_d.delete();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h03, 0);
    for (int j = 3; j >= 0; j--) send_byte(wq[0][8*j +: 8], 0);
    send_byte(wq[1][31:24], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_in_ready", in_ready, 1'b0);
    chk("arst_imem_we", imem_we, 1'b0);
    chk("arst_core_rst_n", core_rst_n, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fin_n = 2; fin_en = 1'b1;
    load(16'h0003, 1'b0, 1);
    finish_check(3, 1'b0, 2);
    do_clear();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mipse_ctrl.md
# mipse_ctrl

Boot and run sequencer for the `mipse` single-cycle core. It accepts a program as a byte stream from a host, writes it into instruction memory, and holds the core in reset until loading completes. It then releases the core, counts execution cycles until the core raises `finish`, and reports status. It sits between the host interface and the core/instruction-memory pair in the top level.

## Interface
- `IMEM_AW`, 8, instruction-memory word-address width (depth 2^IMEM_AW words)
- `CNT_W`, 32, cycle-counter width
- `MAX_CYCLES`, 1000000, watchdog limit in core cycles (used only with watchdog compiled in)

- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: one-cycle pulse, begin a load; ignored outside IDLE
- `clear` in 1: one-cycle pulse, abort or finish the session and return to IDLE
- `in_valid` in 1: host byte valid
- `in_data` in 8: host byte
- `in_ready` out 1: controller accepts a byte
- `imem_we` out 1: instruction-memory write strobe
- `imem_addr` out IMEM_AW: instruction-memory word address
- `imem_wdata` out 32: instruction word
- `core_rst_n` out 1: core reset, active-low
- `core_finish` in 1: core `finish` flag
- `busy` out 1: high in HDR0, HDR1, LOAD, RUN
- `done` out 1: high in DONE
- `timeout` out 1: watchdog expired
- `load_err` out 1: bad header
- `cycles` out CNT_W: core cycles executed

## Operation
- Byte transfer occurs on a rising edge with `in_valid & in_ready`. `in_ready` = 1 only in HDR0, HDR1 and LOAD.
- IDLE: `start` moves to HDR0, clears `cycles`, `timeout` and `load_err`, and holds `core_rst_n` = 0.
- HDR0/HDR1: accept word count N, 16-bit big-endian (HDR0 receives the MSB).
  - N = 0 or N > 2^IMEM_AW sets `load_err` and moves to DONE.
  - Otherwise moves to LOAD with the word index at 0.
- LOAD: assemble 4 bytes big-endian (first byte into [31:24]), matching the core's byte-lane order.
  - After the 4th byte, write the word at address = word index, then increment the index.
  - After word N-1 is accepted, move to RUN.
- RUN: `core_rst_n` = 1 (see Timing). `cycles` increments on each edge where `core_rst_n` = 1 and `core_finish` = 0.
  - `core_finish` sampled 1 moves to DONE; `cycles` freezes.
- DONE: `core_rst_n` stays at its value on entry, so the finished core holds its PC.
- `clear` in any non-IDLE state moves to IDLE and drives `core_rst_n` = 0 on the next edge. In HDR0, HDR1 and LOAD it discards the partial word; no further `imem_we` is issued.
- `start` outside IDLE: ignored. `in_valid` outside the load states: ignored.
- `cycles` saturates at all-ones and never wraps.

## Timing
- Reset values: state IDLE, `in_ready` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0, `core_rst_n` = 0, `busy` = 0, `done` = 0, `timeout` = 0, `load_err` = 0, `cycles` = 0.
- All outputs are registered.
- `imem_we` is a one-cycle pulse on the cycle after the edge that accepts the 4th byte of a word. `imem_addr` and `imem_wdata` are valid in the same cycle.
- Release sequence:
  - The final word's `imem_we` is asserted in the first RUN cycle.
  - `core_rst_n` rises on the next edge, 2 cycles after the last byte is accepted.
  - The core's first fetch therefore sees all written words.
- A `finish` sampled on the same edge as the watchdog limit counts as a normal finish: `timeout` stays 0.
- `rst_n` asserted mid-load or mid-run returns to IDLE immediately. The partially loaded instruction memory is not cleared.

## Configuration
- `MIPSE_CTRL_WDOG_EN` defined: watchdog compiled in.
  - In RUN, when `cycles` reaches MAX_CYCLES without `core_finish`, move to DONE.
  - Set `timeout` = 1 and drive `core_rst_n` = 0 on the same edge.
- Undefined: no watchdog. RUN ends only on `core_finish` or `clear`; `timeout` is constant 0.

## Test plan
- Header 0x0002, bytes 3C 08 12 34 10 00 FF FF:
  - two `imem_we` pulses, addr 0 data 0x3C081234, addr 1 data 0x1000FFFF;
  - `core_rst_n` high 2 cycles after the last byte;
  - a core model asserting finish 5 cycles after release gives `done` = 1 and `cycles` = 5.
- Header 0x0000: `load_err` = 1, `done` = 1, no `imem_we`, `core_rst_n` stays 0.
- With IMEM_AW = 8, header 0x0101: `load_err` = 1. Header 0x0100 loads 256 words to addresses 0..255.
- `in_valid` toggling randomly with 1–3 idle cycles between bytes: same written words as the back-to-back case.
- With `MIPSE_CTRL_WDOG_EN` and MAX_CYCLES = 10, core never finishes: `timeout` = 1, `cycles` = 10, `core_rst_n` = 0. Without the macro, `cycles` keeps counting past 10.
- `clear` after 6 bytes of a 2-word load: one `imem_we` only, return to IDLE, `busy` = 0. A new `start` then loads correctly from address 0.
